// File: rtl/ff_reg_pkg.sv
// ff_reg_pkg: shared widths for ff_reg instances and ROB slot packing
package ff_reg_pkg;
    localparam int DEFAULT_WIDTH = 32;
    localparam int REGISTER_SIZE = 32;
    localparam int REG_ADDRESS_SIZE = 5;
    localparam int ROB_SLOT_WIDTH = REGISTER_SIZE + REG_ADDRESS_SIZE + 2;
    // Slot layout {data, dest, we, valid}: all-zero reads as an invalid entry
    function automatic logic [ROB_SLOT_WIDTH-1:0] rob_pack(
        input logic [REGISTER_SIZE-1:0]    data,
        input logic [REG_ADDRESS_SIZE-1:0] addr,
        input logic                        we,
        input logic                        valid
    );
        return {data, addr, we, valid};
    endfunction
endpackage

// File: rtl/ff_reg.sv
// ff_reg: stallable, erasable storage register used as a ROB slot or pipeline stage
module ff_reg
    import ff_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             write,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             stall,
    input  logic             erase,
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] q;
    always_ff @(posedge write or negedge reset)
        if (!reset)
            q <= '0;
        else if (erase)
            q <= '0;
        else if (!stall)
            q <= in;
    assign out = q;
endmodule

// File: tb/tb_ff_reg.sv
// tb_ff_reg: directed and randomized checks of ff_reg at WIDTH 8 and ROB slot width
module tb_ff_reg;
    import ff_reg_pkg::*;
    logic                      write = 1'b0;
    logic                      reset = 1'b0;
    logic                      stall = 1'b0;
    logic                      erase = 1'b0;
    logic [7:0]                in8 = '0;
    logic [7:0]                o8;
    logic [ROB_SLOT_WIDTH-1:0] in39 = '0;
    logic [ROB_SLOT_WIDTH-1:0] o39;
    logic [7:0]                m8 = '0;
    logic [ROB_SLOT_WIDTH-1:0] m39 = '0;
    int                        n_checks = 0;
    int                        n_err = 0;

    ff_reg #(.WIDTH(8)) u8 (
        .write(write), .reset(reset), .in(in8), .stall(stall), .erase(erase), .out(o8)
    );
    ff_reg #(.WIDTH(ROB_SLOT_WIDTH)) u39 (
        .write(write), .reset(reset), .in(in39), .stall(stall), .erase(erase), .out(o39)
    );

    always #5 write = ~write;

    task automatic check8(input string tag, input logic [7:0] exp);
        n_checks++;
        assert (o8 === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o8, exp);
        end
    endtask

    task automatic check39(input string tag, input logic [ROB_SLOT_WIDTH-1:0] exp);
        n_checks++;
        assert (o39 === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o39, exp);
        end
    endtask

    // Expected register content after one rising edge, from the stated priority rules
    task automatic tick();
        @(posedge write);
        if (reset) begin
            if (erase) begin
                m8 = '0;
                m39 = '0;
            end else if (!stall) begin
                m8 = in8;
                m39 = in39;
            end
        end
        @(negedge write);
    endtask

    initial begin
        logic [63:0] r;
        @(negedge write);
        in8 = 8'hA5;
        #1 check8("reset_initial", 8'h00);
        check39("reset_initial_w", '0);
        tick();
        tick();
        check8("reset_held_edges", 8'h00);
        reset = 1'b1;
        #1 check8("reset_release_no_edge", 8'h00);
        tick();
        check8("load_after_release", 8'hA5);
        in8 = 8'h3C;
        tick();
        check8("load_3c", 8'h3C);
        stall = 1'b1;
        in8 = 8'hFF;
        tick();
        tick();
        tick();
        check8("stall_hold", 8'h3C);
        stall = 1'b0;
        erase = 1'b1;
        in8 = 8'h77;
        tick();
        check8("erase_beats_load", 8'h00);
        erase = 1'b0;
        in8 = 8'h3C;
        tick();
        erase = 1'b1;
        stall = 1'b1;
        tick();
        check8("erase_beats_stall", 8'h00);
        erase = 1'b0;
        stall = 1'b0;
        in8 = 8'h55;
        tick();
        check8("load_55", 8'h55);
        #2 reset = 1'b0;
        #1 check8("async_reset_midcycle", 8'h00);
        m8 = '0;
        m39 = '0;
        @(negedge write);
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in8 = 8'(i);
            #1 check8("b2b_before_edge", 8'(i - 1));
            tick();
            check8("b2b_load", 8'(i));
        end
        in39 = rob_pack(32'hDEADBEEF, 5'd7, 1'b1, 1'b1);
        tick();
        check39("wide_load", {32'hDEADBEEF, 5'd7, 1'b1, 1'b1});
        erase = 1'b1;
        tick();
        check39("wide_erase", '0);
        erase = 1'b0;
        for (int i = 0; i < 300; i++) begin
            r = {$urandom(), $urandom()};
            in8 = r[7:0];
            r = {$urandom(), $urandom()};
            in39 = r[ROB_SLOT_WIDTH-1:0];
            stall = 1'($urandom_range(0, 1));
            erase = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 15) != 0);
            if (!reset) begin
                m8 = '0;
                m39 = '0;
            end
            #1 check8("rand_pre_edge", m8);
            check39("rand_pre_edge_w", m39);
            tick();
            check8("rand_post_edge", m8);
            check39("rand_post_edge_w", m39);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
